// File: rtl/score_board.sv
// Two-player BCD score keeper with a game-over FSM and a four-digit
// multiplexed seven-segment scan (p1 tens/ones on the left, p2 on the right).
module score_board #(
  parameter int REFRESH_DIV = 50000,
  parameter int WIN_SCORE   = 11
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_point_p1,
  input  logic       i_point_p2,
  input  logic       i_clear,
  output logic [3:0] o_digit,
  output logic [3:0] o_anode,
  output logic [7:0] o_score_p1,
  output logic [7:0] o_score_p2,
  output logic       o_game_over,
  output logic       o_winner
);

  localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [7:0]      WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  typedef enum logic {PLAY, OVER} state_t;

  state_t           state;
  logic [7:0]       nxt_p1;
  logic [7:0]       nxt_p2;
  logic             win_p1;
  logic             win_p2;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic             cnt_term;
  logic [3:0]       digit_nxt;

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (s[7:4] == 4'd9) ? 4'd0 : s[7:4] + 4'd1;
    end else begin
      r[3:0] = s[3:0] + 4'd1;
      r[7:4] = s[7:4];
    end
    return r;
  endfunction

  always_comb begin
    nxt_p1 = i_point_p1 ? bcd_inc(o_score_p1) : o_score_p1;
    nxt_p2 = i_point_p2 ? bcd_inc(o_score_p2) : o_score_p2;
    win_p1 = (nxt_p1 == WIN_BCD);
    win_p2 = (nxt_p2 == WIN_BCD);
  end

  // Game FSM; a simultaneous win is credited to player 1.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      state       <= PLAY;
      o_score_p1  <= 8'h00;
      o_score_p2  <= 8'h00;
      o_game_over <= 1'b0;
      o_winner    <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          o_score_p1 <= nxt_p1;
          o_score_p2 <= nxt_p2;
          if (win_p1 || win_p2) begin
            state       <= OVER;
            o_game_over <= 1'b1;
            o_winner    <= ~win_p1;
          end
        end
        default: begin
          state <= OVER;
        end
      endcase
    end
  end

  // Outputs are registered from the next index so o_anode always tracks idx.
  always_comb begin
    cnt_term = (cnt == CNT_MAX);
    idx_nxt  = cnt_term ? idx + 2'd1 : idx;
    case (idx_nxt)
      2'd0:    digit_nxt = o_score_p2[3:0];
      2'd1:    digit_nxt = o_score_p2[7:4];
      2'd2:    digit_nxt = o_score_p1[3:0];
      default: digit_nxt = o_score_p1[7:4];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      idx     <= 2'd0;
      o_anode <= 4'b1110;
      o_digit <= 4'd0;
    end else begin
      cnt     <= cnt_term ? '0 : cnt + CNT_W'(1);
      idx     <= idx_nxt;
      o_anode <= ~(4'b0001 << idx_nxt);
      o_digit <= digit_nxt;
    end
  end

endmodule

// File: tb/tb_score_board.sv
// Directed bench for score_board with REFRESH_DIV=4, WIN_SCORE=11.
module tb_score_board;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       p1 = 1'b0;
  logic       p2 = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] digit;
  logic [3:0] anode;
  logic [7:0] s1;
  logic [7:0] s2;
  logic       go;
  logic       win;

  int n_run  = 0;
  int n_fail = 0;

  score_board #(.REFRESH_DIV(4), .WIN_SCORE(11)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_point_p1 (p1),
    .i_point_p2 (p2),
    .i_clear    (clr),
    .o_digit    (digit),
    .o_anode    (anode),
    .o_score_p1 (s1),
    .o_score_p2 (s2),
    .o_game_over(go),
    .o_winner   (win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic a, input logic b, input logic c);
    p1 = a; p2 = b; clr = c;
    tick();
    p1 = 1'b0; p2 = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_anode(input string tag, input logic [3:0] exp);
    for (int i = 0; i < 20; i++) begin
      if (anode == exp) break;
      tick();
    end
    chk(tag, anode, exp);
  endtask

  task automatic check_scores(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                              input logic eg, input logic ew);
    chk({tag, "_p1"}, s1, e1);
    chk({tag, "_p2"}, s2, e2);
    chk({tag, "_go"}, go, eg);
    chk({tag, "_win"}, win, ew);
  endtask

  initial begin
    logic [3:0] exp_an;
    #2;
    // Reset and idle scan
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_scores("rst", 8'h00, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      exp_an = ~(4'b0001 << ((k / 4) % 4));
      chk($sformatf("scan_an%0d", k), anode, exp_an);
      chk($sformatf("scan_dg%0d", k), digit, 4'd0);
      tick();
    end

    // Ten p1 points: BCD carry 09 -> 10
    for (int i = 1; i <= 10; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      if (i == 9) chk("p1_nine", s1, 8'h09);
    end
    check_scores("p1_ten", 8'h10, 8'h00, 1'b0, 1'b0);
    tick();
    wait_anode("wait_idx3", 4'b0111);
    chk("idx3_digit", digit, 4'd1);
    wait_anode("wait_idx2", 4'b1011);
    chk("idx2_digit", digit, 4'd0);

    // Eleventh point wins; further points ignored
    pulse(1'b1, 1'b0, 1'b0);
    check_scores("p1_win", 8'h11, 8'h00, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check_scores("over_p1", 8'h11, 8'h00, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check_scores("over_p2", 8'h11, 8'h00, 1'b1, 1'b0);
    tick();
    wait_anode("wait_idx2b", 4'b1011);
    chk("over_idx2_digit", digit, 4'd1);

    // Clear in OVER beats a simultaneous p2 point
    pulse(1'b0, 1'b1, 1'b1);
    check_scores("clr_over", 8'h00, 8'h00, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("p2_one", s2, 8'h01);
    tick();
    wait_anode("wait_idx0", 4'b1110);
    chk("idx0_digit", digit, 4'd1);

    // Player 2 wins alone
    for (int i = 0; i < 9; i++) pulse(1'b0, 1'b1, 1'b0);
    check_scores("p2_ten", 8'h00, 8'h10, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check_scores("p2_win", 8'h00, 8'h11, 1'b1, 1'b1);
    tick();
    wait_anode("wait_idx1", 4'b1101);
    chk("idx1_digit", digit, 4'd1);
    pulse(1'b0, 1'b0, 1'b1);
    check_scores("clr_only", 8'h00, 8'h00, 1'b0, 1'b0);

    // Clear priority in PLAY
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b1);
    check_scores("clr_play", 8'h00, 8'h00, 1'b0, 1'b0);

    // Simultaneous win goes to player 1
    for (int i = 0; i < 10; i++) pulse(1'b1, 1'b1, 1'b0);
    check_scores("both_ten", 8'h10, 8'h10, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    check_scores("both_win", 8'h11, 8'h11, 1'b1, 1'b0);

    // Reset mid-scan at index 2 overrides clear and points
    wait_anode("wait_idx2c", 4'b1011);
    tick();
    rst = 1'b1; p1 = 1'b1; clr = 1'b1;
    tick();
    rst = 1'b0; p1 = 1'b0; clr = 1'b0;
    check_scores("rst_mid", 8'h00, 8'h00, 1'b0, 1'b0);
    chk("rst_mid_digit", digit, 4'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_hold%0d", k), anode, 4'b1110);
      tick();
    end
    chk("rst_adv", anode, 4'b1101);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
